// File: rtl/ai_move_seq.sv
// AI turn sequencer: asks the point calculator for candidates, vets them against the board and places one or two stones.
// place_vld holds until place_rdy; optional raster-scan fallback on retry exhaustion under MOVE_SEQ_SCAN_FALLBACK_EN.
module ai_move_seq #(
    parameter int BRD_DIM      = 19,
    parameter int CALC_TIMEOUT = 1023,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       first_move,
    output logic       calc_en,
    input  logic       calc_done,
    input  logic [4:0] calc_x,
    input  logic [4:0] calc_y,
    output logic       board_rd,
    output logic [4:0] board_x,
    output logic [4:0] board_y,
    input  logic       board_occ,
    output logic       place_vld,
    output logic [4:0] place_x,
    output logic [4:0] place_y,
    input  logic       place_rdy,
    output logic       busy,
    output logic       turn_done,
    output logic       err
);

    localparam int TW = (CALC_TIMEOUT > 1) ? $clog2(CALC_TIMEOUT + 1) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [5:0]    DIM6     = 6'(BRD_DIM);
    localparam logic [TW-1:0] TMO_LAST = TW'(CALC_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE, CALC, WAIT, CHECK, OCC, PLACE, NEXT
`ifdef MOVE_SEQ_SCAN_FALLBACK_EN
        , SCAN
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    stones_q, stones_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [4:0]    cx_q, cx_d, cy_q, cy_d;
    logic          td_q, td_d, err_q, err_d;
    logic          retry_ev;
`ifdef MOVE_SEQ_SCAN_FALLBACK_EN
    logic [4:0]    sx_q, sx_d, sy_q, sy_d;
    logic          sph_q, sph_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            stones_q <= '0;
            retry_q  <= '0;
            tmo_q    <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            td_q     <= 1'b0;
            err_q    <= 1'b0;
`ifdef MOVE_SEQ_SCAN_FALLBACK_EN
            sx_q     <= '0;
            sy_q     <= '0;
            sph_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            stones_q <= stones_d;
            retry_q  <= retry_d;
            tmo_q    <= tmo_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            td_q     <= td_d;
            err_q    <= err_d;
`ifdef MOVE_SEQ_SCAN_FALLBACK_EN
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            sph_q    <= sph_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        stones_d = stones_q;
        retry_d  = retry_q;
        tmo_d    = tmo_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        td_d     = 1'b0;
        err_d    = 1'b0;
        retry_ev = 1'b0;
`ifdef MOVE_SEQ_SCAN_FALLBACK_EN
        sx_d     = sx_q;
        sy_d     = sy_q;
        sph_d    = sph_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    stones_d = first_move ? 2'd1 : 2'd2;
                    retry_d  = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (calc_done) begin
                    if (({1'b0, calc_x} >= DIM6) || ({1'b0, calc_y} >= DIM6)) begin
                        retry_ev = 1'b1;
                    end else begin
                        cx_d    = calc_x;
                        cy_d    = calc_y;
                        state_d = CHECK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    retry_ev = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            CHECK: state_d = OCC;
            OCC: begin
                if (board_occ) retry_ev = 1'b1;
                else           state_d  = PLACE;
            end
            PLACE: begin
                if (place_rdy) begin
                    stones_d = stones_q - 2'd1;
                    retry_d  = '0;
                    if (stones_q == 2'd1) begin
                        td_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: state_d = CALC;
`ifdef MOVE_SEQ_SCAN_FALLBACK_EN
            SCAN: begin
                // Phase 0 strobes the read, phase 1 consumes board_occ for the same cell.
                if (!sph_q) begin
                    sph_d = 1'b1;
                end else begin
                    sph_d = 1'b0;
                    if (!board_occ) begin
                        cx_d    = sx_q;
                        cy_d    = sy_q;
                        state_d = PLACE;
                    end else if ((sx_q == 5'(BRD_DIM - 1)) && (sy_q == 5'(BRD_DIM - 1))) begin
                        err_d   = 1'b1;
                        td_d    = 1'b1;
                        state_d = IDLE;
                    end else if (sx_q == 5'(BRD_DIM - 1)) begin
                        sx_d = '0;
                        sy_d = sy_q + 5'd1;
                    end else begin
                        sx_d = sx_q + 5'd1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (retry_ev) begin
            if (retry_q < RETRY_MX) begin
                retry_d = retry_q + RW'(1);
                state_d = CALC;
            end else begin
`ifdef MOVE_SEQ_SCAN_FALLBACK_EN
                sx_d    = '0;
                sy_d    = '0;
                sph_d   = 1'b0;
                state_d = SCAN;
`else
                err_d   = 1'b1;
                td_d    = 1'b1;
                state_d = IDLE;
`endif
            end
        end
    end

    assign calc_en   = (state_q == CALC);
    assign place_vld = (state_q == PLACE);
    assign busy      = (state_q != IDLE);
    assign place_x   = cx_q;
    assign place_y   = cy_q;
    assign turn_done = td_q;
    assign err       = err_q;
`ifdef MOVE_SEQ_SCAN_FALLBACK_EN
    assign board_rd  = (state_q == CHECK) || ((state_q == SCAN) && !sph_q);
    assign board_x   = (state_q == SCAN) ? sx_q : cx_q;
    assign board_y   = (state_q == SCAN) ? sy_q : cy_q;
`else
    assign board_rd  = (state_q == CHECK);
    assign board_x   = cx_q;
    assign board_y   = cy_q;
`endif

endmodule

// File: doc/ai_move_seq.md
AI_MOVE_SEQ -- requirements
Module: ai_move_seq

Interface
REQ-001 SHALL have parameter BRD_DIM, default 19, board width and height in cells.
REQ-002 SHALL have parameter CALC_TIMEOUT, default 1023, maximum cycles to wait for calc_done.
REQ-003 SHALL have parameter MAX_RETRY, default 3, maximum rejected candidates per stone.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  AI turn request, sampled in IDLE only.
REQ-007 SHALL have port first_move  input  1  opening turn, sampled with start: 1 = one stone, 0 = two stones.
REQ-008 SHALL have port calc_en  output  1  one-cycle enable pulse to the point calculator.
REQ-009 SHALL have port calc_done  input  1  calculator result valid.
REQ-010 SHALL have ports calc_x, calc_y  input  5 each  candidate cell, valid while calc_done=1.
REQ-011 SHALL have port board_rd  output  1  one-cycle board occupancy read strobe.
REQ-012 SHALL have ports board_x, board_y  output  5 each  read address, held from board_rd until board_occ is sampled.
REQ-013 SHALL have port board_occ  input  1  cell occupied, valid exactly one cycle after board_rd.
REQ-014 SHALL have port place_vld  output  1  stone placement request.
REQ-015 SHALL have ports place_x, place_y  output  5 each  placement cell, stable while place_vld=1.
REQ-016 SHALL have port place_rdy  input  1  placement accepted when high together with place_vld.
REQ-017 SHALL have ports busy, turn_done, err  output  1 each  turn in progress; one-cycle end-of-turn pulse; one-cycle failure pulse.

Function
REQ-018 SHALL implement states IDLE, CALC, WAIT, CHECK, OCC, PLACE, NEXT, SCAN.
REQ-019 SHALL, in IDLE with start=1, latch stones_left = first_move ? 1 : 2, clear retry count, assert busy, and enter CALC next cycle.
REQ-020 SHALL, in CALC, pulse calc_en for exactly one cycle, clear the timeout counter, and enter WAIT.
REQ-021 SHALL, in WAIT, latch calc_x/calc_y when calc_done=1 and enter CHECK; if the counter reaches CALC_TIMEOUT first, count one retry.
REQ-022 SHALL reject a candidate with calc_x >= BRD_DIM or calc_y >= BRD_DIM without a board read, counting one retry.
REQ-023 SHALL, in CHECK, pulse board_rd with the latched cell and enter OCC; in OCC, sample board_occ: 0 -> PLACE, 1 -> count one retry.
REQ-024 SHALL, on a retry with retry count < MAX_RETRY, increment it and re-enter CALC; at MAX_RETRY, take the exhaustion path (REQ-032/033).
REQ-025 SHALL, in PLACE, hold place_vld=1 and place_x/y constant until place_rdy=1; the handshake completes in that cycle.
REQ-026 SHALL, on handshake, decrement stones_left and clear retry count; if the result is 0, pulse turn_done, drop busy and return to IDLE; otherwise enter NEXT and, one cycle later, CALC.
REQ-027 SHALL ignore start while busy=1; start held high across IDLE re-entry SHALL begin a new turn one cycle after turn_done.
REQ-028 SHALL keep busy=1 in every state except IDLE.
REQ-029 SHALL use 5-bit coordinate arithmetic; the scan counter SHALL never exceed BRD_DIM-1 on either axis.

Reset
REQ-030 SHALL, on reset=1, force IDLE immediately, regardless of state, including mid-handshake.
REQ-031 SHALL, on reset, drive calc_en, board_rd, place_vld, busy, turn_done, err = 0, coordinate outputs = 0, and clear stones_left, retry count, timeout counter and scan counters.

Configuration
REQ-032 SHALL, with MOVE_SEQ_SCAN_FALLBACK_EN defined, enter SCAN on exhaustion: raster-scan x-fastest from (0,0) using the board_rd/board_occ protocol (2 cycles per cell); the first empty cell goes to PLACE. If no cell is empty after (BRD_DIM-1,BRD_DIM-1), pulse err and turn_done together and return to IDLE.
REQ-033 SHALL, without MOVE_SEQ_SCAN_FALLBACK_EN, on exhaustion pulse err and turn_done in the same cycle and return to IDLE; stones already placed are kept. The SCAN state and scan counters SHALL not be synthesized.

Verification
REQ-034 SHALL cover this case: start with first_move=1; calc returns (9,9); board_occ=0; place_rdy=1 -> exactly one place at (9,9), then turn_done; err=0.
REQ-035 SHALL cover this case: start with first_move=0; calc returns (3,4) then (5,6); place_rdy delayed 4 cycles -> place_x/y stable during the stall; two placements; calc_en pulsed twice.
REQ-036 SHALL cover this case: calc returns (20,2), then an occupied (1,1), then (2,2) empty -> two retries, placement at (2,2), err=0.
REQ-037 SHALL cover this case: calc_done never asserted, MAX_RETRY=3 -> 4 calc_en pulses spaced by CALC_TIMEOUT. Without the macro: err and turn_done pulse. With the macro: a scan places at the first empty cell, (0,0) when the board is empty.
REQ-038 SHALL cover this case: reset asserted while place_vld=1 -> place_vld and busy are 0 in the same cycle; no turn_done; the next start runs normally.
REQ-039 SHALL cover this case: with the macro and a fully occupied board, exhaustion -> 361 board_rd strobes, then err and turn_done together.
